// File: rtl/aurora_rx_pkg.sv
// ============================================================================
// Module      : aurora_rx_pkg
// Description : Shared types and constants for the Aurora RX demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aurora_rx_pkg;

  // Per-port frame state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Width of the per-port drop/truncation counter.
  localparam int c_CNT_W   = 16;

  // FIFO entries kept free while a frame is open, so a closing tlast fits.
  localparam int c_RESERVE = 1;

endpackage

`default_nettype wire

// File: rtl/aurora_rx_chan.sv
// ============================================================================
// Module      : aurora_rx_chan
// Description : One output port of the Aurora RX demux: frame FSM
//               (IDLE/PASS/DROP), FWFT FIFO with registered output, sticky
//               overflow flag and optional saturating drop counter
//               (enabled by defining AURORA_RX_DEMUX_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_rx_chan
  import aurora_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SIM        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mask,
  input  logic [31:0]        in_tdata,
  input  logic [3:0]         in_tkeep,
  input  logic               in_tvalid,
  input  logic               in_tlast,
  input  logic               stat_clr,
  input  logic               m_tready,
  output logic [31:0]        m_tdata,
  output logic [3:0]         m_tkeep,
  output logic               m_tvalid,
  output logic               m_tlast,
  output logic               ovf,
  output logic [c_CNT_W-1:0] drop_cnt
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_DEPTH    = c_LW'(FIFO_DEPTH);
  localparam logic [c_LW-1:0] c_NEED_OPN = c_LW'(c_RESERVE + 1);
  localparam logic [c_LW-1:0] c_NEED_END = c_LW'(c_RESERVE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [36:0]       r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_LW-1:0]   r_level;   // entries in memory plus output register
  logic [c_LW-1:0]   w_free;
  logic [c_LW-1:0]   w_mem_cnt;
  logic              w_wr;
  logic              w_wr_last;
  logic              w_evt;
  logic              w_pop;
  logic              w_load;

  // Free space uses the level before this cycle's write and read.
  assign w_free    = c_DEPTH - r_level;
  assign w_mem_cnt = r_level - c_LW'(m_tvalid);
  assign w_pop     = m_tvalid & m_tready;
  assign w_load    = (w_mem_cnt != '0) && (!m_tvalid || m_tready);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, write decision, forced tlast on truncation, drop event.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wr_last   = in_tlast;
    w_evt       = 1'b0;
    if (in_tvalid) begin
      case (r_state)
        ST_IDLE: begin
          if (mask) begin
            if (!in_tlast) w_state_nxt = ST_DROP;
          end else if (w_free >= c_NEED_OPN) begin
            w_wr = 1'b1;
            if (!in_tlast) w_state_nxt = ST_PASS;
          end else begin
            w_evt = 1'b1;
            if (!in_tlast) w_state_nxt = ST_DROP;
          end
        end
        ST_PASS: begin
          if (in_tlast) begin
            w_wr        = (w_free >= c_NEED_END);
            w_state_nxt = ST_IDLE;
          end else if (w_free >= c_NEED_OPN) begin
            w_wr = 1'b1;
          end else begin
            // Last reserved slot: close the frame here and drop the rest.
            w_wr        = (w_free >= c_NEED_END);
            w_wr_last   = 1'b1;
            w_evt       = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end
        ST_DROP: begin
          if (in_tlast) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset, level and pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_wr_last, in_tkeep, in_tdata};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_level <= r_level + c_LW'(w_wr) - c_LW'(w_pop);
    end
  end

  // Registered FWFT output; only reloads when empty or handshaking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (w_load) begin
      m_tvalid <= 1'b1;
      {m_tlast, m_tkeep, m_tdata} <= r_mem[r_rd_ptr];
    end else if (w_pop) begin
      m_tvalid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (w_evt)    ovf <= 1'b1;
    else if (stat_clr) ovf <= 1'b0;
  end

`ifdef AURORA_RX_DEMUX_CNT_EN
  // Saturating drop counter; a new event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (w_evt) begin
      if (stat_clr)            drop_cnt <= c_CNT_W'(1);
      else if (~&drop_cnt)     drop_cnt <= drop_cnt + c_CNT_W'(1);
    end else if (stat_clr) begin
      drop_cnt <= '0;
    end
  end
`else
  assign drop_cnt = '0;
`endif

  generate
    if (SIM != 0) begin : g_sim_chk
      a_pass_reserve : assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_PASS) |-> (w_free >= c_NEED_END));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/aurora_axi_rx_demux.sv
// ============================================================================
// Module      : aurora_axi_rx_demux
// Description : Fans the Aurora RX AXI-Stream out to ETHCOUNT per-port
//               streams. No backpressure upstream: ports drop or truncate
//               frames instead of stalling. Drop counters are built when
//               AURORA_RX_DEMUX_CNT_EN is defined, otherwise tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_axi_rx_demux
  import aurora_rx_pkg::*;
#(
  parameter int ETHCOUNT   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SIM        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ETHCOUNT-1:0]           eth_mask,
  input  logic [31:0]                   axis_s_tdata,
  input  logic [3:0]                    axis_s_tkeep,
  input  logic                          axis_s_tvalid,
  input  logic                          axis_s_tlast,
  input  logic [ETHCOUNT-1:0]           axis_m_tready,
  output logic [ETHCOUNT*32-1:0]        axis_m_tdata,
  output logic [ETHCOUNT*4-1:0]         axis_m_tkeep,
  output logic [ETHCOUNT-1:0]           axis_m_tvalid,
  output logic [ETHCOUNT-1:0]           axis_m_tlast,
  input  logic                          stat_clr,
  output logic [ETHCOUNT-1:0]           ovf,
  output logic [ETHCOUNT*c_CNT_W-1:0]   drop_cnt
);

  logic [31:0] r_tdata;
  logic [3:0]  r_tkeep;
  logic        r_tvalid;
  logic        r_tlast;

  // Stage 0: register the Aurora beat unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_tdata  <= axis_s_tdata;
      r_tkeep  <= axis_s_tkeep;
      r_tvalid <= axis_s_tvalid;
      r_tlast  <= axis_s_tlast;
    end
  end

  generate
    for (genvar g = 0; g < ETHCOUNT; g++) begin : g_chan
      aurora_rx_chan #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SIM        (SIM)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .mask      (eth_mask[g]),
        .in_tdata  (r_tdata),
        .in_tkeep  (r_tkeep),
        .in_tvalid (r_tvalid),
        .in_tlast  (r_tlast),
        .stat_clr  (stat_clr),
        .m_tready  (axis_m_tready[g]),
        .m_tdata   (axis_m_tdata[g*32 +: 32]),
        .m_tkeep   (axis_m_tkeep[g*4 +: 4]),
        .m_tvalid  (axis_m_tvalid[g]),
        .m_tlast   (axis_m_tlast[g]),
        .ovf       (ovf[g]),
        .drop_cnt  (drop_cnt[g*c_CNT_W +: c_CNT_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_aurora_axi_rx_demux.sv
// ============================================================================
// Module      : tb_aurora_axi_rx_demux
// Description : Self-checking bench for aurora_axi_rx_demux. Expected beats
//               are queued per port when frames are driven and compared as
//               the ports hand them off. Counter expectations follow
//               AURORA_RX_DEMUX_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aurora_axi_rx_demux;

  localparam int ETHCOUNT   = 4;
  localparam int FIFO_DEPTH = 16;
`ifdef AURORA_RX_DEMUX_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic [ETHCOUNT-1:0]    eth_mask;
  logic [31:0]            axis_s_tdata;
  logic [3:0]             axis_s_tkeep;
  logic                   axis_s_tvalid;
  logic                   axis_s_tlast;
  logic [ETHCOUNT-1:0]    axis_m_tready;
  logic [ETHCOUNT*32-1:0] axis_m_tdata;
  logic [ETHCOUNT*4-1:0]  axis_m_tkeep;
  logic [ETHCOUNT-1:0]    axis_m_tvalid;
  logic [ETHCOUNT-1:0]    axis_m_tlast;
  logic                   stat_clr;
  logic [ETHCOUNT-1:0]    ovf;
  logic [ETHCOUNT*16-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_cyc = 0;
  logic [36:0] exp_q [ETHCOUNT][$];

  aurora_axi_rx_demux #(
    .ETHCOUNT   (ETHCOUNT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SIM        (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .eth_mask      (eth_mask),
    .axis_s_tdata  (axis_s_tdata),
    .axis_s_tkeep  (axis_s_tkeep),
    .axis_s_tvalid (axis_s_tvalid),
    .axis_s_tlast  (axis_s_tlast),
    .axis_m_tready (axis_m_tready),
    .axis_m_tdata  (axis_m_tdata),
    .axis_m_tkeep  (axis_m_tkeep),
    .axis_m_tvalid (axis_m_tvalid),
    .axis_m_tlast  (axis_m_tlast),
    .stat_clr      (stat_clr),
    .ovf           (ovf),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_cnt(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction

  function automatic logic [31:0] dat(input int base, input int i);
    logic [15:0] h;
    h = 16'(base + i);
    return {h, h};
  endfunction

  // Scoreboard: compare each output handshake against the port's queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (first_cyc < 0 && axis_m_tvalid[0]) first_cyc = cyc;
      for (int p = 0; p < ETHCOUNT; p++) begin
        if (axis_m_tvalid[p] && axis_m_tready[p]) begin
          logic [36:0] got;
          logic [36:0] e;
          got = {axis_m_tlast[p], axis_m_tkeep[p*4 +: 4], axis_m_tdata[p*32 +: 32]};
          checks++;
          if (exp_q[p].size() == 0) begin
            errors++;
            $display("FAIL beat_port%0d: got=%h required=none (unexpected beat)", p, got);
          end else begin
            e = exp_q[p].pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL beat_port%0d: got=%h required=%h", p, got, e);
            end
          end
        end
      end
    end
  end

  // Drive beats first..last of an n-beat frame; queue them for 'ports'.
  task automatic send_range(input int first, input int last_i, input int n,
                            input int base, input logic [3:0] ports);
    for (int i = first; i <= last_i; i++) begin
      logic        lst;
      logic [3:0]  kp;
      lst = (i == n);
      kp  = lst ? 4'h3 : 4'hF;
      for (int p = 0; p < ETHCOUNT; p++)
        if (ports[p]) exp_q[p].push_back({lst, kp, dat(base, i)});
      axis_s_tdata  = dat(base, i);
      axis_s_tkeep  = kp;
      axis_s_tlast  = lst;
      axis_s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    axis_s_tvalid = 1'b0;
    axis_s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input logic [3:0] ports);
    send_range(1, n, n, base, ports);
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (i < 300 && (exp_q[0].size() + exp_q[1].size() +
                       exp_q[2].size() + exp_q[3].size()) != 0) begin
      @(posedge clk); #1;
      i++;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int p = 0; p < ETHCOUNT; p++) begin
      checks++;
      if (exp_q[p].size() != 0) begin
        errors++;
        $display("FAIL %s_drain_port%0d: pending=%0d required=0", name, p, exp_q[p].size());
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (axis_m_tvalid !== '0) begin errors++; $display("FAIL reset_tvalid: got=%h required=0", axis_m_tvalid); end
    checks++;
    if (axis_m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got=%h required=0", axis_m_tdata); end
    checks++;
    if (axis_m_tkeep !== '0 || axis_m_tlast !== '0) begin
      errors++; $display("FAIL reset_tkeep_tlast: got=%h/%h required=0/0", axis_m_tkeep, axis_m_tlast);
    end
    checks++;
    if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got=%h required=0", ovf); end
    checks++;
    if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got=%h required=0", drop_cnt); end
  endtask

  task automatic test_fanout();
    int start;
    eth_mask      = '0;
    axis_m_tready = '1;
    first_cyc     = -1;
    start         = cyc;
    send_frame(8, 0, 4'hF);
    wait_drain("fanout");
    checks++;
    if (first_cyc !== start + 3) begin
      errors++; $display("FAIL fanout_latency: got=%0d required=%0d", first_cyc - start, 3);
    end
    checks++;
    if (ovf !== '0) begin errors++; $display("FAIL fanout_ovf: got=%h required=0", ovf); end
  endtask

  task automatic test_mask();
    eth_mask = 4'b0100;
    send_frame(3, 16'h20, 4'b1011);
    wait_drain("mask");
    eth_mask = '0;
    checks++;
    if (drop_cnt[47:32] !== 16'd0) begin
      errors++; $display("FAIL mask_drop_cnt2: got=%h required=0", drop_cnt[47:32]);
    end
    checks++;
    if (ovf !== '0) begin errors++; $display("FAIL mask_ovf: got=%h required=0", ovf); end
  endtask

  task automatic test_truncation();
    axis_m_tready = 4'b1101;
    for (int i = 1; i <= 16; i++)
      exp_q[1].push_back({(i == 16), 4'hF, dat(16'h100, i)});
    send_frame(20, 16'h100, 4'b1101);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (axis_m_tvalid[1] !== 1'b1 || axis_m_tdata[63:32] !== dat(16'h100, 1)) begin
      errors++; $display("FAIL trunc_hold: got=%b/%h required=1/%h", axis_m_tvalid[1],
                         axis_m_tdata[63:32], dat(16'h100, 1));
    end
    checks++;
    if (ovf !== 4'b0010) begin errors++; $display("FAIL trunc_ovf: got=%b required=0010", ovf); end
    checks++;
    if (drop_cnt[31:16] !== exp_cnt(1)) begin
      errors++; $display("FAIL trunc_cnt1: got=%h required=%h", drop_cnt[31:16], exp_cnt(1));
    end
    send_frame(4, 16'h200, 4'b1101);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt[31:16] !== exp_cnt(2)) begin
      errors++; $display("FAIL trunc_cnt2: got=%h required=%h", drop_cnt[31:16], exp_cnt(2));
    end
    axis_m_tready = '1;
    wait_drain("trunc");
    checks++;
    if (ovf !== 4'b0010 || drop_cnt[15:0] !== 16'd0 || drop_cnt[63:32] !== 32'd0) begin
      errors++; $display("FAIL trunc_others: got=%b/%h required=0010/0", ovf, drop_cnt);
    end
  endtask

  task automatic test_reserve();
    axis_m_tready = 4'b1110;
    send_frame(14, 16'h300, 4'hF);
    send_frame(2, 16'h400, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovf[0] !== 1'b0 || drop_cnt[15:0] !== 16'd0) begin
      errors++; $display("FAIL reserve14: got=%b/%h required=0/0", ovf[0], drop_cnt[15:0]);
    end
    axis_m_tready = '1;
    wait_drain("reserve14");
    axis_m_tready = 4'b1110;
    send_frame(15, 16'h500, 4'hF);
    send_frame(2, 16'h600, 4'b1110);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovf[0] !== 1'b1 || drop_cnt[15:0] !== exp_cnt(1)) begin
      errors++; $display("FAIL reserve15: got=%b/%h required=1/%h", ovf[0], drop_cnt[15:0], exp_cnt(1));
    end
    axis_m_tready = '1;
    wait_drain("reserve15");
  endtask

  task automatic test_stat_clr();
    axis_m_tready = 4'b0111;
    send_frame(16, 16'h700, 4'hF);
    send_frame(1, 16'h800, 4'b0111);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt[63:48] !== exp_cnt(1)) begin
      errors++; $display("FAIL statclr_pre: got=%h required=%h", drop_cnt[63:48], exp_cnt(1));
    end
    // Second drop on port 3, with stat_clr on the edge that records it.
    for (int p = 0; p < 3; p++) exp_q[p].push_back({1'b1, 4'h3, dat(16'h900, 1)});
    axis_s_tdata  = dat(16'h900, 1);
    axis_s_tkeep  = 4'h3;
    axis_s_tlast  = 1'b1;
    axis_s_tvalid = 1'b1;
    @(posedge clk); #1;
    axis_s_tvalid = 1'b0;
    axis_s_tlast  = 1'b0;
    stat_clr      = 1'b1;
    @(posedge clk); #1;
    stat_clr      = 1'b0;
    checks++;
    if (ovf !== 4'b1000) begin errors++; $display("FAIL statclr_evt_ovf: got=%b required=1000", ovf); end
    checks++;
    if (drop_cnt !== {exp_cnt(1), 48'd0}) begin
      errors++; $display("FAIL statclr_evt_cnt: got=%h required=%h", drop_cnt, {exp_cnt(1), 48'd0});
    end
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    checks++;
    if (ovf !== '0 || drop_cnt !== '0) begin
      errors++; $display("FAIL statclr_alone: got=%b/%h required=0/0", ovf, drop_cnt);
    end
    axis_m_tready = '1;
    wait_drain("statclr");
  endtask

  task automatic test_async_reset();
    axis_m_tready = '1;
    send_range(1, 4, 8, 16'hA00, 4'hF);
    #2;
    checks++;
    if (axis_m_tvalid !== 4'hF) begin
      errors++; $display("FAIL areset_pre_valid: got=%h required=f", axis_m_tvalid);
    end
    rst = 1'b1;
    #1;
    for (int p = 0; p < ETHCOUNT; p++) exp_q[p].delete();
    checks++;
    if (axis_m_tvalid !== '0 || axis_m_tdata !== '0 || axis_m_tkeep !== '0 ||
        axis_m_tlast !== '0 || ovf !== '0 || drop_cnt !== '0) begin
      errors++; $display("FAIL areset_outputs: got=%h/%h required=0/0", axis_m_tvalid, axis_m_tdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_range(5, 8, 8, 16'hA00, 4'hF);
    wait_drain("areset");
    checks++;
    if (ovf !== '0) begin errors++; $display("FAIL areset_ovf: got=%h required=0", ovf); end
  endtask

  initial begin
    rst           = 1'b1;
    eth_mask      = '0;
    axis_s_tdata  = '0;
    axis_s_tkeep  = '0;
    axis_s_tvalid = 1'b0;
    axis_s_tlast  = 1'b0;
    axis_m_tready = '1;
    stat_clr      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_fanout();
    test_mask();
    test_truncation();
    test_reserve();
    test_stat_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
